cp0_unit: RTL

//  Coprocessor-0 for the P7 pipeline. It is the consumer of the exc/slot/ERET/MTC0 fields that the stage registers carry down the pipe.

---
 rtl/cp0_pkg.sv | 28 ++
 rtl/cp0_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and the exception handler entry point.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT     = 5'd0,
      EXC_ADEL    = 5'd4,
      EXC_ADES    = 5'd5,
      EXC_SYSCALL = 5'd8,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } exc_code_e;

   localparam int IM_LSB      = 10;
   localparam int IP_LSB      = 10;
   localparam int EXL_BIT     = 1;
   localparam int IE_BIT      = 0;
   localparam int BD_BIT      = 31;
   localparam int EXCCODE_LSB = 2;

   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: raises the exception/interrupt request and
// holds SR, Cause and EPC for the handler, ERET and MFC0.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h0000_0000,
   parameter int          HWINT_W    = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        pc_in,
   input  logic [4:0]         exc_in,
   input  logic               slot_in,
   input  logic               eret_in,
   input  logic               mtc0_in,
   input  logic [4:0]         addr_in,
   input  logic [31:0]        din,
   input  logic [HWINT_W-1:0] hw_int,
   output logic               req,
   output logic [31:0]        epc_out,
   output logic [31:0]        dout
);

   logic [HWINT_W-1:0] sr_im_q, sr_im_d;
   logic               sr_exl_q, sr_exl_d;
   logic               sr_ie_q, sr_ie_d;
   logic               cause_bd_q, cause_bd_d;
   logic [HWINT_W-1:0] cause_ip_q, cause_ip_d;
   logic [4:0]         cause_exc_q, cause_exc_d;
   logic [31:0]        epc_q, epc_d;

   logic        int_req, exc_req;
   logic [31:0] epc_fault;
   logic [31:0] sr_word, cause_word;

   assign int_req = sr_ie_q & ~sr_exl_q & (|(sr_im_q & hw_int));
   assign exc_req = (exc_in != 5'd0) & ~sr_exl_q;
   assign req     = int_req | exc_req;

   // A delay-slot fault restarts at the branch so the branch re-executes.
   assign epc_fault = (slot_in ? (pc_in - 32'd4) : pc_in) & ~32'd3;

   always_comb begin
      sr_im_d     = sr_im_q;
      sr_exl_d    = sr_exl_q;
      sr_ie_d     = sr_ie_q;
      cause_bd_d  = cause_bd_q;
      cause_ip_d  = hw_int;
      cause_exc_d = cause_exc_q;
      epc_d       = epc_q;
      if (req) begin
         sr_exl_d    = 1'b1;
         cause_bd_d  = slot_in;
         cause_exc_d = int_req ? EXC_INT : exc_in;
         epc_d       = epc_fault;
      end else begin
         if (mtc0_in) begin
            if (addr_in == REG_SR) begin
               sr_im_d  = din[IM_LSB +: HWINT_W];
               sr_exl_d = din[EXL_BIT];
               sr_ie_d  = din[IE_BIT];
            end else if (addr_in == REG_EPC) begin
               epc_d = din;
            end
         end
         if (eret_in) begin
            sr_exl_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_im_q     <= '0;
         sr_exl_q    <= 1'b0;
         sr_ie_q     <= 1'b0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= '0;
         cause_exc_q <= 5'd0;
         epc_q       <= 32'd0;
      end else begin
         sr_im_q     <= sr_im_d;
         sr_exl_q    <= sr_exl_d;
         sr_ie_q     <= sr_ie_d;
         cause_bd_q  <= cause_bd_d;
         cause_ip_q  <= cause_ip_d;
         cause_exc_q <= cause_exc_d;
         epc_q       <= epc_d;
      end
   end

   always_comb begin
      sr_word                            = 32'd0;
      sr_word[IM_LSB +: HWINT_W]         = sr_im_q;
      sr_word[EXL_BIT]                   = sr_exl_q;
      sr_word[IE_BIT]                    = sr_ie_q;
      cause_word                         = 32'd0;
      cause_word[BD_BIT]                 = cause_bd_q;
      cause_word[IP_LSB +: HWINT_W]      = cause_ip_q;
      cause_word[EXCCODE_LSB +: 5]       = cause_exc_q;
   end

   always_comb begin
      unique case (addr_in)
         REG_SR:    dout = sr_word;
         REG_CAUSE: dout = cause_word;
         REG_EPC:   dout = epc_q;
         REG_PRID:  dout = PRID_VALUE;
         default:   dout = 32'd0;
      endcase
   end

   // Forward an in-flight EPC write so an ERET in the very next slot redirects correctly.
   assign epc_out = (mtc0_in && (addr_in == REG_EPC) && !req) ? din : epc_q;

endmodule
